// File: rtl/bcd_serial_add_ctrl_if.sv
// Request, result and digit-adder signals of the serial packed-BCD adder controller.
// The master side is the requesting datapath together with the shared digit adder.
interface bcd_serial_add_ctrl_if #(
    parameter int NDIG = 4
);
    logic                start;
    logic [4*NDIG-1:0]   a;
    logic [4*NDIG-1:0]   b;
    logic                ci;
    logic [3:0]          dig_a;
    logic [3:0]          dig_b;
    logic                dig_ci;
    logic [3:0]          dig_s;
    logic                dig_co;
    logic [4*NDIG-1:0]   sum;
    logic                co;
    logic                err;
    logic                busy;
    logic                done;

    modport master (
        output start, a, b, ci, dig_s, dig_co,
        input  dig_a, dig_b, dig_ci, sum, co, err, busy, done
    );

    modport slave (
        input  start, a, b, ci, dig_s, dig_co,
        output dig_a, dig_b, dig_ci, sum, co, err, busy, done
    );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder sequencer: feeds one digit pair per clock, LSD first,
// to an external combinational digit adder and chains the decimal carry.
module bcd_serial_add_ctrl #(
    parameter int NDIG = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_serial_add_ctrl_if.slave  bus
);
    localparam int IW = $clog2(NDIG);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [IW-1:0]       idx_reg;
    logic [4*NDIG-1:0]   a_reg, b_reg, sum_reg;
    logic                carry_reg, co_reg, err_reg;
    logic [2*NDIG-1:0]   digit_bad;
    logic                any_bad, accept, last_digit;

    // Operands are checked straight off the bus so err can be decided on the accepting edge.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_chk
        assign digit_bad[2*gi]   = (bus.a[4*gi +: 4] > 4'd9);
        assign digit_bad[2*gi+1] = (bus.b[4*gi +: 4] > 4'd9);
    end

    assign any_bad    = |digit_bad;
    assign last_digit = (idx_reg == IW'(NDIG-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = any_bad ? DONE : RUN;
                end
            end
            RUN:     if (last_digit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            co_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else if (accept) begin
            idx_reg   <= '0;
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            sum_reg   <= '0;
            carry_reg <= bus.ci;
            co_reg    <= 1'b0;
            err_reg   <= any_bad;
        end else if (state_reg == RUN) begin
            sum_reg[{idx_reg, 2'b00} +: 4] <= bus.dig_s;
            carry_reg                      <= bus.dig_co;
            if (last_digit) begin
                co_reg  <= bus.dig_co;
                idx_reg <= '0;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    // The digit adder sees zeros whenever no digit pair is in flight.
    assign bus.dig_a  = (state_reg == RUN) ? a_reg[{idx_reg, 2'b00} +: 4] : 4'd0;
    assign bus.dig_b  = (state_reg == RUN) ? b_reg[{idx_reg, 2'b00} +: 4] : 4'd0;
    assign bus.dig_ci = (state_reg == RUN) ? carry_reg : 1'b0;

    assign bus.sum  = sum_reg;
    assign bus.co   = co_reg;
    assign bus.err  = err_reg;
    assign bus.busy = (state_reg != IDLE);
    assign bus.done = (state_reg == DONE);
endmodule
